y86_seq_controller: RTL and testbench

- Stage sequencer for the sequential Y86-64 core.
- Walks one instruction at a time through fetch, decode, execute, memory, writeback and PC update by issuing one-hot stage enables.
- Holds the memory stage until the data memory acknowledges, and maintains the processor status code (stat).
- Sits above the fetch/decode/execute/memory/writeback blocks, and replaces the hand-driven clocking used by the stage testbenches.

---
 rtl/y86_pkg.sv | 46 ++++
 rtl/y86_seq_controller_if.sv | 26 ++
 rtl/y86_mem_wait_timer.sv | 36 +++
 rtl/y86_seq_controller.sv | 152 +++++++++++++++
 tb/tb_y86_seq_controller.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86-64 core: instruction codes,
// status codes, controller state encoding and instruction classification.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_CMOVXX = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } ctrl_state_e;

  // Instructions that touch data memory and therefore wait for mem_ack.
  function automatic logic is_mem_icode(input logic [3:0] icode);
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_seq_controller_if.sv
// Stage-enable and fetch/data-memory handshake bundle between the sequencer
// (master) and the datapath stage blocks (slave).
interface y86_seq_controller_if;
  logic [3:0] icode;
  logic       instr_valid;
  logic       imem_error;
  logic       mem_ack;
  logic       dmem_error;
  logic       fetch_en;
  logic       decode_en;
  logic       execute_en;
  logic       memory_en;
  logic       writeback_en;
  logic       pcupd_en;
  logic       mem_req;

  modport master (
    input  icode, instr_valid, imem_error, mem_ack, dmem_error,
    output fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en, mem_req
  );

  modport slave (
    output icode, instr_valid, imem_error, mem_ack, dmem_error,
    input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en, mem_req
  );
endinterface

// File: rtl/y86_mem_wait_timer.sv
// Counts MEMORY-state cycles spent waiting for the data memory; expired is
// high during the MEM_TIMEOUT-th waiting cycle.
module y86_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded with 1 so the count equals the ordinal of the current MEMORY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(1);
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/y86_seq_controller.sv
// Stage sequencer for the sequential Y86-64 core: one instruction at a time
// through F/D/E/M/W/PC-update with registered one-hot enables and status.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop_req,
  input  logic                     clear,
  y86_seq_controller_if.master     bus,
  output logic [2:0]               stat,
  output logic                     busy,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instr_count
);

  ctrl_state_e      state_q, state_d;
  stat_e            stat_q, stat_d;
  logic [3:0]       icode_q, icode_d;
  logic [5:0]       en_q, en_d;
  logic             mem_req_q, mem_req_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             mem_expired;

  y86_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == S_EXECUTE),
    .count_en (mem_req_q && !bus.mem_ack),
    .expired  (mem_expired)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    instr_d = instr_q;
    cycle_d = (busy_q && cycle_q != '1) ? cycle_q + 1'b1 : cycle_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        icode_d = bus.icode;
        if (bus.imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (!bus.instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALTED;
        end else if (bus.icode == I_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALTED;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      // An ack in the same cycle as timeout expiry wins over the timeout.
      S_MEMORY: begin
        if (!is_mem_icode(icode_q)) begin
          state_d = S_WRITEBACK;
        end else if (bus.mem_ack) begin
          if (bus.dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (mem_expired) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        if (instr_q != '1) instr_d = instr_q + 1'b1;
        state_d = stop_req ? S_IDLE : S_FETCH;
      end
      S_HALTED: begin
        if (clear) begin
          stat_d  = STAT_AOK;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they align with the state register.
    en_d      = '0;
    case (state_d)
      S_FETCH:     en_d[0] = 1'b1;
      S_DECODE:    en_d[1] = 1'b1;
      S_EXECUTE:   en_d[2] = 1'b1;
      S_MEMORY:    en_d[3] = 1'b1;
      S_WRITEBACK: en_d[4] = 1'b1;
      S_PCUPD:     en_d[5] = 1'b1;
      default:     en_d    = '0;
    endcase
    mem_req_d = (state_d == S_MEMORY) && is_mem_icode(icode_d);
    busy_d    = (state_d != S_IDLE) && (state_d != S_HALTED);
    halted_d  = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stat_q    <= STAT_AOK;
      icode_q   <= '0;
      en_q      <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      icode_q   <= icode_d;
      en_q      <= en_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
    end
  end

  assign bus.fetch_en     = en_q[0];
  assign bus.decode_en    = en_q[1];
  assign bus.execute_en   = en_q[2];
  assign bus.memory_en    = en_q[3];
  assign bus.writeback_en = en_q[4];
  assign bus.pcupd_en     = en_q[5];
  assign bus.mem_req      = mem_req_q;
  assign stat             = stat_q;
  assign busy             = busy_q;
  assign halted           = halted_q;
  assign cycle_count      = cycle_q;
  assign instr_count      = instr_q;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Bench for y86_seq_controller: a phase-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_y86_seq_controller;
  localparam int MEM_TIMEOUT = 16;
  localparam logic [15:0] MEM_MASK = 16'h0F30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop_req = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  y86_seq_controller_if if1();
  y86_seq_controller_if if2();

  logic [2:0]  stat1, stat2;
  logic        busy1, busy2, halted1, halted2;
  logic [31:0] cyc1, ins1;
  logic [2:0]  cyc2, ins2;

  y86_seq_controller #(.CNT_W(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req), .clear(clear),
    .bus(if1), .stat(stat1), .busy(busy1), .halted(halted1),
    .cycle_count(cyc1), .instr_count(ins1)
  );

  y86_seq_controller #(.CNT_W(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req), .clear(clear),
    .bus(if2), .stat(stat2), .busy(busy2), .halted(halted2),
    .cycle_count(cyc2), .instr_count(ins2)
  );

  assign if2.icode       = if1.icode;
  assign if2.instr_valid = if1.instr_valid;
  assign if2.imem_error  = if1.imem_error;
  assign if2.mem_ack     = if1.mem_ack;
  assign if2.dmem_error  = if1.dmem_error;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..6 = F,D,E,M,W,P, 7 halted.
  int          m_phase = 0;
  logic [2:0]  m_stat  = 3'd1;
  logic [3:0]  m_icq   = 4'd0;
  int          m_wait  = 0;
  longint      m_cyc   = 0;
  longint      m_ins   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_stat = 3'd1; m_icq = 4'd0; m_wait = 0; m_cyc = 0; m_ins = 0;
    end else begin
      if (m_phase >= 1 && m_phase <= 6) m_cyc++;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: begin
          m_icq = if1.icode;
          if (if1.imem_error)          begin m_stat = 3'd3; m_phase = 7; end
          else if (!if1.instr_valid)   begin m_stat = 3'd4; m_phase = 7; end
          else if (if1.icode == 4'd0)  begin m_stat = 3'd2; m_phase = 7; end
          else m_phase = 2;
        end
        2: m_phase = 3;
        3: begin m_phase = 4; m_wait = 0; end
        4: begin
          if (!MEM_MASK[m_icq]) m_phase = 5;
          else begin
            m_wait++;
            if (if1.mem_ack) begin
              if (if1.dmem_error) begin m_stat = 3'd3; m_phase = 7; end
              else m_phase = 5;
            end else if (m_wait == MEM_TIMEOUT) begin
              m_stat = 3'd3; m_phase = 7;
            end
          end
        end
        5: m_phase = 6;
        6: begin m_ins++; m_phase = stop_req ? 0 : 1; end
        7: if (clear) begin m_stat = 3'd1; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic longint clamp(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    logic [5:0]  en;
    logic        mreq;
    logic [11:0] exp_ctrl;
    en   = (m_phase >= 1 && m_phase <= 6) ? 6'(1 << (m_phase - 1)) : 6'd0;
    mreq = (m_phase == 4) && MEM_MASK[m_icq];
    exp_ctrl = {en, mreq, m_stat, (m_phase >= 1 && m_phase <= 6), (m_phase == 7)};
    check("ctrl", {if1.pcupd_en, if1.writeback_en, if1.memory_en, if1.execute_en,
                   if1.decode_en, if1.fetch_en, if1.mem_req, stat1, busy1, halted1}, exp_ctrl);
    check("cycle_count", cyc1, clamp(m_cyc, 32));
    check("instr_count", ins1, clamp(m_ins, 32));
    check("ctrl_w3", {if2.pcupd_en, if2.writeback_en, if2.memory_en, if2.execute_en,
                      if2.decode_en, if2.fetch_en, if2.mem_req, stat2, busy2, halted2}, exp_ctrl);
    check("cycle_count_w3", cyc2, clamp(m_cyc, 3));
    check("instr_count_w3", ins2, clamp(m_ins, 3));
  end

  // Data memory responder: ack after ack_delay extra cycles of mem_req (-1 = never).
  int   ack_delay = -1;
  logic derr = 1'b0;
  int   mcnt = 0;
  always @(negedge clk) begin
    if (if1.mem_req) begin
      mcnt++;
      if1.mem_ack = (ack_delay >= 0) && (mcnt == ack_delay + 1);
    end else begin
      mcnt = 0;
      if1.mem_ack = 1'b0;
    end
    if1.dmem_error = if1.mem_ack && derr;
  end

  task automatic set_instr(input logic [3:0] ic, input logic v, input logic ie,
                           input logic stp, input int ad, input logic de);
    if1.icode = ic; if1.instr_valid = v; if1.imem_error = ie;
    stop_req = stp; ack_delay = ad; derr = de;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic run(input int max, output int memcyc, output bit saw_p);
    memcyc = 0; saw_p = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < max; i++) begin
      memcyc += int'(if1.memory_en);
      saw_p  |= if1.pcupd_en;
      if (!busy1) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("FAIL run_timeout: still busy after %0d cycles, expected idle/halted", max);
  endtask

  initial begin
    int mc;
    bit sp;
    set_instr(4'h1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_stat", stat1, 3'd1);
    check("rst_flags", {busy1, halted1, if1.mem_req, if1.fetch_en, if1.pcupd_en}, 5'b0);
    check("rst_counts", {cyc1, ins1}, 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // nop, single instruction
    run(40, mc, sp);
    check("nop_instr", ins1, 32'd1);
    check("nop_cycles", cyc1, 32'd6);
    check("nop_memcyc", mc, 1);
    check("nop_pcupd", sp, 1'b1);
    check("nop_idle", {busy1, halted1}, 2'b00);

    // mrmovq with ack after 3 extra cycles
    do_reset();
    set_instr(4'h5, 1'b1, 1'b0, 1'b1, 3, 1'b0);
    run(40, mc, sp);
    check("mrmovq_memcyc", mc, 4);
    check("mrmovq_cycles", cyc1, 32'd9);
    check("mrmovq_instr", ins1, 32'd1);
    check("mrmovq_stat", stat1, 3'd1);

    // pushq, no ack: timeout
    do_reset();
    set_instr(4'hA, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    run(60, mc, sp);
    check("to_stat", stat1, 3'd3);
    check("to_halted", halted1, 1'b1);
    check("to_mem_req", if1.mem_req, 1'b0);
    check("to_instr", ins1, 32'd0);
    check("to_memcyc", mc, 16);
    check("to_cycles", cyc1, 32'd19);
    check("to_pcupd", sp, 1'b0);
    pulse_clear();
    check("clr_stat", stat1, 3'd1);
    check("clr_state", {busy1, halted1}, 2'b00);

    // halt instruction, then clear+start together
    set_instr(4'h0, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    run(20, mc, sp);
    check("hlt_stat", stat1, 3'd2);
    check("hlt_halted", halted1, 1'b1);
    check("hlt_pcupd", sp, 1'b0);
    check("hlt_cycles", cyc1, 32'd20);
    clear = 1'b1; start = 1'b1; @(negedge clk); clear = 1'b0; start = 1'b0;
    check("clrstart_state", {busy1, halted1, if1.fetch_en}, 3'b000);
    check("clrstart_stat", stat1, 3'd1);
    @(negedge clk);
    check("clrstart_nofetch", {busy1, if1.fetch_en}, 2'b00);

    // fetch faults: ADR wins over INS, then INS alone
    set_instr(4'h3, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    run(20, mc, sp);
    check("adr_prio_stat", stat1, 3'd3);
    pulse_clear();
    set_instr(4'h3, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    run(20, mc, sp);
    check("ins_stat", stat1, 3'd4);
    pulse_clear();

    // ret with immediate ack carrying dmem_error
    set_instr(4'h9, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    run(20, mc, sp);
    check("dmem_stat", stat1, 3'd3);
    check("dmem_memcyc", mc, 1);
    check("dmem_cycles", cyc1, 32'd26);
    pulse_clear();

    // back-to-back opq, with start/clear while busy ignored
    set_instr(4'h6, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1; start = 1'b1; @(negedge clk); clear = 1'b0; start = 1'b0;
    repeat (6) @(negedge clk);
    stop_req = 1'b1;
    begin
      int k;
      k = 0;
      while (busy1 && k < 20) begin @(negedge clk); k++; end
      if (busy1) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_timeout: busy=%0b expected 0", busy1);
      end
    end
    check("b2b_instr", ins1, 32'd2);
    check("b2b_cycles", cyc1, 32'd38);
    check("sat_cycles_w3", cyc2, 3'd7);
    check("sat_instr_w3", ins2, 3'd2);

    // asynchronous reset in the middle of a memory wait
    do_reset();
    set_instr(4'h5, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    begin
      int k;
      k = 0;
      while (!if1.mem_req && k < 10) begin @(negedge clk); k++; end
    end
    @(negedge clk);
    check("pre_rst_mem_req", if1.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", if1.mem_req, 1'b0);
    check("arst_enables", {if1.fetch_en, if1.decode_en, if1.execute_en, if1.memory_en,
                           if1.writeback_en, if1.pcupd_en}, 6'b0);
    check("arst_counts", {cyc1, ins1}, 64'd0);
    check("arst_state", {busy1, halted1, stat1}, {2'b00, 3'd1});
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
